// File: rtl/id_ex_stage.sv
// ID/EX pipeline register with load-use hazard detection and decoder enable.
// Optional statistics counters are built when ID_EX_STATS_EN is defined.
module id_ex_stage #(
  parameter int DATA_W = 32,
  parameter int RA_W   = 5,
  parameter int CNT_W  = 16
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     stall,
  input  logic                     flush,
  input  logic [10:0]              id_ctrl,
  input  logic [5:0]               id_opcode,
  input  logic [5:0]               id_funct,
  input  logic [RA_W-1:0]          id_rs,
  input  logic [RA_W-1:0]          id_rt,
  input  logic [RA_W-1:0]          id_rd,
  input  logic [4:0]               id_shamt,
  input  logic signed [DATA_W-1:0] id_rdata1,
  input  logic signed [DATA_W-1:0] id_rdata2,
  input  logic signed [DATA_W-1:0] id_imm,
  input  logic [DATA_W-1:0]        id_pc4,
  output logic [10:0]              ex_ctrl,
  output logic [5:0]               ex_opcode,
  output logic [5:0]               ex_funct,
  output logic [RA_W-1:0]          ex_rs,
  output logic [RA_W-1:0]          ex_rt,
  output logic [RA_W-1:0]          ex_rd,
  output logic [4:0]               ex_shamt,
  output logic signed [DATA_W-1:0] ex_rdata1,
  output logic signed [DATA_W-1:0] ex_rdata2,
  output logic signed [DATA_W-1:0] ex_imm,
  output logic [DATA_W-1:0]        ex_pc4,
  output logic                     ex_valid,
  output logic                     load_use,
  output logic                     ctrl_enable,
  output logic [CNT_W-1:0]         stall_cnt,
  output logic [CNT_W-1:0]         bubble_cnt
);

  localparam int MEMREAD_BIT = 8;

  logic bubble;

  // Hazard is judged from the load already in EX against the operands now in ID.
  assign load_use    = ex_valid & ex_ctrl[MEMREAD_BIT] & (ex_rt != '0) &
                       ((ex_rt == id_rs) | (ex_rt == id_rt));
  assign ctrl_enable = ~load_use;
  assign bubble      = flush | load_use;

  // ---- ID -> EX boundary ----
  always_ff @(posedge clk) begin
    if (reset) begin
      ex_ctrl   <= '0;
      ex_opcode <= '0;
      ex_funct  <= '0;
      ex_rs     <= '0;
      ex_rt     <= '0;
      ex_rd     <= '0;
      ex_shamt  <= '0;
      ex_rdata1 <= '0;
      ex_rdata2 <= '0;
      ex_imm    <= '0;
      ex_pc4    <= '0;
      ex_valid  <= 1'b0;
    end else if (stall) begin
      ex_valid  <= ex_valid;
    end else if (bubble) begin
      ex_ctrl   <= '0;
      ex_opcode <= '0;
      ex_funct  <= '0;
      ex_rs     <= '0;
      ex_rt     <= '0;
      ex_rd     <= '0;
      ex_shamt  <= '0;
      ex_rdata1 <= '0;
      ex_rdata2 <= '0;
      ex_imm    <= '0;
      ex_pc4    <= '0;
      ex_valid  <= 1'b0;
    end else begin
      ex_ctrl   <= id_ctrl;
      ex_opcode <= id_opcode;
      ex_funct  <= id_funct;
      ex_rs     <= id_rs;
      ex_rt     <= id_rt;
      ex_rd     <= id_rd;
      ex_shamt  <= id_shamt;
      ex_rdata1 <= id_rdata1;
      ex_rdata2 <= id_rdata2;
      ex_imm    <= id_imm;
      ex_pc4    <= id_pc4;
      ex_valid  <= 1'b1;
    end
  end

`ifdef ID_EX_STATS_EN
  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (&v) ? v : v + {{(CNT_W-1){1'b0}}, 1'b1};
  endfunction

  always_ff @(posedge clk) begin
    if (reset) begin
      stall_cnt  <= '0;
      bubble_cnt <= '0;
    end else if (stall) begin
      stall_cnt  <= sat_inc(stall_cnt);
    end else if (bubble) begin
      bubble_cnt <= sat_inc(bubble_cnt);
    end
  end
`else
  assign stall_cnt  = '0;
  assign bubble_cnt = '0;
`endif

endmodule
